// File: rtl/prg_chk_pkg.sv
// prg_chk_pkg: shared FSM state type and fail codes for the PRG period checker
package prg_chk_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_SHORT = 2'd1;
  localparam logic [1:0] FC_DUP   = 2'd2;
  localparam logic [1:0] FC_ABORT = 2'd3;
endpackage

// File: rtl/prg_seen_map.sv
// prg_seen_map: 2^W flag register, sync clear/set, combinational single-flag read
module prg_seen_map #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         set_en,
  input  logic [W-1:0] set_idx,
  input  logic [W-1:0] rd_idx,
  output logic         hit
);
  logic [2**W-1:0] map_q, map_d;
  // set is applied after clear so a same-cycle clr+set leaves the indexed flag set
  always_comb begin
    map_d = clr ? '0 : map_q;
    if (set_en) map_d[set_idx] = 1'b1;
  end
  always_ff @(posedge clk) map_q <= rst ? '0 : map_d;
  assign hit = map_q[rd_idx];
endmodule

// File: rtl/prg_period_checker.sv
// prg_period_checker: verifies a PRG state stream is one full cycle and reports period/pass/first duplicate
module prg_period_checker
  import prg_chk_pkg::*;
#(
  parameter int W             = 8,
  parameter int EXPECT_PERIOD = 2**W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] prg_in,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [1:0]   fail_code,
  output logic [W:0]   period,
  output logic [W-1:0] first_dup
);
  state_e       state_q, state_d;
  logic [W-1:0] seed_q, seed_d, dup_q, dup_d;
  logic [W:0]   count_q, count_d, period_q, period_d;
  logic [1:0]   fc_q, fc_d;
  logic         pass_q, pass_d, clr, set_en, hit, is_pass;
  prg_seen_map #(.W(W)) u_map (
    .clk(CLK), .rst(RST), .clr(clr), .set_en(set_en),
    .set_idx(prg_in), .rd_idx(prg_in), .hit(hit)
  );
  assign is_pass = count_q == (W+1)'(EXPECT_PERIOD);
  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    count_d  = count_q;
    period_d = period_q;
    fc_d     = fc_q;
    pass_d   = pass_q;
    dup_d    = dup_q;
    clr      = 1'b0;
    set_en   = 1'b0;
    if (state_q != SCAN && start) begin
      state_d  = SCAN;
      seed_d   = prg_in;
      count_d  = (W+1)'(1);
      period_d = '0;
      fc_d     = FC_NONE;
      pass_d   = 1'b0;
      dup_d    = '0;
      clr      = 1'b1;
      set_en   = 1'b1;
    end else if (state_q == SCAN) begin
      if (abort) begin
        state_d  = DONE;
        fc_d     = FC_ABORT;
        period_d = count_q;
      end else if (prg_in == seed_q) begin
        state_d  = DONE;
        period_d = count_q;
        pass_d   = is_pass;
        fc_d     = is_pass ? FC_NONE : FC_SHORT;
      end else if (hit) begin
        state_d  = DONE;
        fc_d     = FC_DUP;
        dup_d    = prg_in;
        period_d = count_q;
      end else begin
        set_en  = 1'b1;
        count_d = count_q + 1'b1;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      seed_q   <= '0;
      count_q  <= '0;
      period_q <= '0;
      fc_q     <= FC_NONE;
      pass_q   <= 1'b0;
      dup_q    <= '0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      count_q  <= count_d;
      period_q <= period_d;
      fc_q     <= fc_d;
      pass_q   <= pass_d;
      dup_q    <= dup_d;
    end
  end
  assign busy      = state_q == SCAN;
  assign done      = state_q == DONE;
  assign pass      = pass_q;
  assign fail_code = fc_q;
  assign period    = period_q;
  assign first_dup = dup_q;
endmodule
